// File: rtl/apb_regfile_slave.sv
// apb_regfile_slave: APB register file of DEPTH word registers with a
// programmable number of wait states before PREADY.
// Optional feature: define APB_PSTRB_EN to add the PSTRB byte-strobe input.
// Without it, every valid write updates the full word.
module apb_regfile_slave #(
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic                    PCLK,
  input  logic                    PRESET,
  input  logic [ADDR_WIDTH-1:0]   PADDR,
  input  logic                    PSEL,
  input  logic                    PENABLE,
  input  logic                    PWRITE,
  input  logic [DATA_WIDTH-1:0]   PWDATA,
`ifdef APB_PSTRB_EN
  input  logic [DATA_WIDTH/8-1:0] PSTRB,
`endif
  output logic                    PREADY,
  output logic [DATA_WIDTH-1:0]   PRDATA,
  output logic                    PSLVERR
);

  localparam int unsigned NBYTES = DATA_WIDTH / 8;
  localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t                  state;
  logic [3:0]              cnt;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic                    wr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [NBYTES-1:0]       strb_q;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic [NBYTES-1:0]       strb_in;
  logic                    addr_bad;
  logic                    fire;
  logic                    wr_en;
  logic [IDX_W-1:0]        idx;
  logic [DATA_WIDTH-1:0]   rd_word;
  logic [DATA_WIDTH-1:0]   wr_word;

  // Strobe source: the port when enabled, otherwise all bytes
  always_comb begin
    strb_in = '1;
`ifdef APB_PSTRB_EN
    strb_in = PSTRB;
`endif
  end

  // Range check on the latched address; an unknown index is rejected in simulation
  always_comb begin
    addr_bad = ({1'b0, addr_q} >= DEPTH_W);
    if ((^addr_q) === 1'bx) addr_bad = 1'b1;
  end

  // Word select, completion strobe and strobed write-data merge
  always_comb begin
    idx     = addr_q[IDX_W-1:0];
    fire    = (state == WAIT) && PSEL && PENABLE && (cnt == 4'd0);
    wr_en   = fire && wr_q && !addr_bad;
    rd_word = mem[idx];
    wr_word = rd_word;
    for (int unsigned b = 0; b < NBYTES; b++) begin
      if (strb_q[b]) wr_word[8*b +: 8] = wdata_q[8*b +: 8];
    end
  end

  // Transfer FSM with registered PREADY/PRDATA/PSLVERR
  always_ff @(posedge PCLK) begin
    if (!PRESET) begin
      state   <= IDLE;
      cnt     <= '0;
      PREADY  <= 1'b0;
      PRDATA  <= '0;
      PSLVERR <= 1'b0;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      strb_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          PREADY  <= 1'b0;
          PRDATA  <= '0;
          PSLVERR <= 1'b0;
          if (PSEL && !PENABLE) begin
            addr_q  <= PADDR;
            wr_q    <= PWRITE;
            wdata_q <= PWDATA;
            strb_q  <= strb_in;
            cnt     <= 4'(WAIT_STATES);
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (!PSEL) begin
            state <= IDLE;
          end else if (PENABLE) begin
            if (cnt != 4'd0) begin
              cnt <= cnt - 4'd1;
            end else begin
              state   <= RESP;
              PREADY  <= 1'b1;
              PSLVERR <= addr_bad;
              PRDATA  <= (!wr_q && !addr_bad) ? rd_word : '0;
            end
          end
        end
        RESP: begin
          PREADY  <= 1'b0;
          PRDATA  <= '0;
          PSLVERR <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Register array: cleared by reset, written on the edge entering RESP
  always_ff @(posedge PCLK) begin
    if (!PRESET) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[idx] <= wr_word;
    end
  end

endmodule

// File: tb/tb_apb_regfile_slave.sv
// tb_apb_regfile_slave: directed bench for apb_regfile_slave. Three instances
// share one bus, with WAIT_STATES 1 (main), 0 and 3.
// Define APB_PSTRB_EN for both RTL and bench to exercise byte strobes.
module tb_apb_regfile_slave;

  logic        pclk = 1'b0;
  logic        preset;
  logic [7:0]  paddr;
  logic        psel, penable, pwrite;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;

  logic        pready,  pready0,  pready3;
  logic [31:0] prdata,  prdata0,  prdata3;
  logic        pslverr, pslverr0, pslverr3;

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] model [16];
  logic [31:0] rd;

  always #5 pclk = ~pclk;

  apb_regfile_slave #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .DEPTH(16), .WAIT_STATES(1)) dut (
    .PCLK(pclk), .PRESET(preset), .PADDR(paddr), .PSEL(psel), .PENABLE(penable),
    .PWRITE(pwrite), .PWDATA(pwdata),
`ifdef APB_PSTRB_EN
    .PSTRB(pstrb),
`endif
    .PREADY(pready), .PRDATA(prdata), .PSLVERR(pslverr));

  apb_regfile_slave #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .DEPTH(16), .WAIT_STATES(0)) dut0 (
    .PCLK(pclk), .PRESET(preset), .PADDR(paddr), .PSEL(psel), .PENABLE(penable),
    .PWRITE(pwrite), .PWDATA(pwdata),
`ifdef APB_PSTRB_EN
    .PSTRB(pstrb),
`endif
    .PREADY(pready0), .PRDATA(prdata0), .PSLVERR(pslverr0));

  apb_regfile_slave #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .DEPTH(16), .WAIT_STATES(3)) dut3 (
    .PCLK(pclk), .PRESET(preset), .PADDR(paddr), .PSEL(psel), .PENABLE(penable),
    .PWRITE(pwrite), .PWDATA(pwdata),
`ifdef APB_PSTRB_EN
    .PSTRB(pstrb),
`endif
    .PREADY(pready3), .PRDATA(prdata3), .PSLVERR(pslverr3));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One APB transfer on the shared bus, checked against the main (WAIT_STATES=1) instance.
  // Bus values are scrambled after the setup edge so only latched values may be used.
  task automatic xfer(input logic wr, input logic [7:0] a, input logic [31:0] d,
                      input logic [3:0] s, input string tag, output logic [31:0] rdata);
    int   lat;
    logic exp_err;
    exp_err = $isunknown(a) || (a >= 8'd16);
    @(negedge pclk);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d; pstrb = s;
    @(negedge pclk);
    penable = 1'b1; paddr = ~a; pwdata = ~d; pwrite = ~wr; pstrb = ~s;
    lat = 0;
    while (!pready && lat < 20) begin
      @(negedge pclk);
      lat++;
    end
    rdata = prdata;
    chk({tag, " latency"}, 32'(lat), 32'd2);
    chk({tag, " pslverr"}, 32'(pslverr), 32'(exp_err));
    if (wr) begin
      chk({tag, " prdata"}, prdata, 32'h0);
      if (!exp_err)
        for (int b = 0; b < 4; b++)
          if (s[b]) model[a[3:0]][8*b +: 8] = d[8*b +: 8];
    end else begin
      chk({tag, " prdata"}, prdata, exp_err ? 32'h0 : model[a[3:0]]);
    end
    @(negedge pclk);
    chk({tag, " pulse_end"}, {prdata[30:0], pready}, 32'h0);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0; pstrb = '0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int first0, first1, first3, n0, n1, n3;
    logic seen;

    for (int i = 0; i < 16; i++) model[i] = '0;
    preset = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0;

    // reset
    repeat (2) @(posedge pclk);
    @(negedge pclk);
    chk("reset pready",  32'(pready),  32'd0);
    chk("reset prdata",  prdata,       32'h0);
    chk("reset pslverr", 32'(pslverr), 32'd0);
    preset = 1'b1;

    // all registers read zero after reset
    for (int i = 0; i < 16; i++) begin
      xfer(1'b0, 8'(i), 32'h0, 4'hF, $sformatf("rst_rd%0d", i), rd);
      chk($sformatf("rst_rd%0d const", i), rd, 32'h0);
    end

    // write i data i, then read back
    for (int i = 0; i < 10; i++) xfer(1'b1, 8'(i), 32'(i), 4'hF, $sformatf("wr%0d", i), rd);
    for (int i = 0; i < 10; i++) begin
      xfer(1'b0, 8'(i), 32'hDEAD_BEEF, 4'hF, $sformatf("rd%0d", i), rd);
      chk($sformatf("rd%0d const", i), rd, 32'(i));
    end

    // back-to-back write then read of the same address
    xfer(1'b1, 8'd12, 32'hCAFE_F00D, 4'hF, "raw_wr", rd);
    xfer(1'b0, 8'd12, 32'h0, 4'hF, "raw_rd", rd);
    chk("raw const", rd, 32'hCAFE_F00D);

    // PSEL dropped during WAIT of a write of FF to addr 0
    @(negedge pclk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'd0; pwdata = 32'hFF; pstrb = 4'hF;
    @(negedge pclk);
    psel = 1'b0; penable = 1'b0;
    seen = 1'b0;
    repeat (5) begin
      @(negedge pclk);
      if (pready || pready0 || pready3) seen = 1'b1;
    end
    chk("abort no pready", 32'(seen), 32'd0);
    xfer(1'b0, 8'd0, 32'h0, 4'hF, "abort_rd0", rd);
    chk("abort_rd0 const", rd, 32'h0);

    // out-of-range and unknown addresses
    xfer(1'b1, 8'd20, 32'hA, 4'hF, "oor_wr20", rd);
    xfer(1'b0, 8'd255, 32'h0, 4'hF, "oor_rd255", rd);
    xfer(1'b1, 'x, 32'hA, 4'hF, "x_wr", rd);
    xfer(1'b0, 8'd4, 32'h0, 4'hF, "rd4_after_err", rd);
    chk("rd4 const", rd, 32'h4);
    xfer(1'b0, 8'd15, 32'h0, 4'hF, "rd15_last", rd);

    // PREADY timing for WAIT_STATES 0, 1, 3 and single-cycle pulse width
    @(negedge pclk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 8'd5;
    @(negedge pclk);
    penable = 1'b1;
    first0 = 0; first1 = 0; first3 = 0; n0 = 0; n1 = 0; n3 = 0;
    for (int e = 1; e <= 7; e++) begin
      @(negedge pclk);
      if (pready0) begin n0++; if (first0 == 0) first0 = e; end
      if (pready)  begin n1++; if (first1 == 0) first1 = e; end
      if (pready3) begin n3++; if (first3 == 0) first3 = e; end
    end
    psel = 1'b0; penable = 1'b0;
    chk("ws0 edge",  32'(first0), 32'd1);
    chk("ws1 edge",  32'(first1), 32'd2);
    chk("ws3 edge",  32'(first3), 32'd4);
    chk("ws0 width", 32'(n0), 32'd1);
    chk("ws1 width", 32'(n1), 32'd1);
    chk("ws3 width", 32'(n3), 32'd1);

    // reset for one edge in the middle of a write of 55 to addr 3
    @(negedge pclk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'd3; pwdata = 32'h55; pstrb = 4'hF;
    @(negedge pclk);
    penable = 1'b1; preset = 1'b0;
    @(negedge pclk);
    chk("midrst pready",  32'(pready | pready0 | pready3), 32'd0);
    chk("midrst prdata",  prdata,       32'h0);
    chk("midrst pslverr", 32'(pslverr), 32'd0);
    preset = 1'b1; psel = 1'b0; penable = 1'b0;
    for (int i = 0; i < 16; i++) model[i] = '0;
    xfer(1'b0, 8'd3, 32'h0, 4'hF, "midrst_rd3", rd);
    chk("midrst_rd3 const", rd, 32'h0);
    xfer(1'b0, 8'd9, 32'h0, 4'hF, "midrst_rd9", rd);

`ifdef APB_PSTRB_EN
    // byte strobes
    xfer(1'b1, 8'd1, 32'hFFFF_FFFF, 4'hF,    "strb_full", rd);
    xfer(1'b1, 8'd1, 32'h1234_5678, 4'b0101, "strb_0101", rd);
    xfer(1'b0, 8'd1, 32'h0, 4'b0000,         "strb_rd", rd);
    chk("strb const", rd, 32'hFF34_FF78);
    xfer(1'b1, 8'd1, 32'h0, 4'b0000,         "strb_none", rd);
    xfer(1'b0, 8'd1, 32'h0, 4'b0000,         "strb_rd2", rd);
    chk("strb_none const", rd, 32'hFF34_FF78);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
